// File: rtl/riscv_pkg.sv
// Shared RV64 core constants: NOP encoding, major opcodes and register field slices.
// IFID_PERF_EN (when defined) enables the stall/flush performance counters in if_id_stage.
package riscv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int OPC_LSB = 0;
    localparam int OPC_MSB = 6;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;
    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;

    // Only R, S and B formats read rs2; for other formats those bits are immediate.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection for the instruction held in IF/ID (purely combinational).
module hazard_detect
    import riscv_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic        valid,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    output logic        hazard
);

    logic [6:0] opcode;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       unused_bits;

    assign opcode = instruction[OPC_MSB:OPC_LSB];
    assign rs1    = instruction[RS1_MSB:RS1_LSB];
    assign rs2    = instruction[RS2_MSB:RS2_LSB];

    // Funct/immediate/rd bits play no part in the hazard decision.
    assign unused_bits = ^{instruction[31:25], instruction[14:7]};

    // A load in EX whose rd feeds a source actually read by the ID instruction; x0 never hazards.
    always_comb begin
        hazard = 1'b0;
        if (valid && idex_mem_read && (idex_rd != 5'd0)) begin
            hazard = (idex_rd == rs1) || (uses_rs2(opcode) && (idex_rd == rs2));
        end
    end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register: captures Fetch output, holds on load-use hazard, bubbles on flush.
// IFID_PERF_EN (when defined) adds perf_stall_cnt / perf_flush_cnt outputs.
module if_id_stage
    import riscv_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic        Clk,
    input  logic        reset,
    input  logic [63:0] if_pc,
    input  logic [31:0] if_instruction,
    input  logic        flush,
    input  logic        idex_mem_read,
    input  logic [4:0]  idex_rd,
    output logic [63:0] id_pc,
    output logic [31:0] id_instruction,
    output logic        id_valid,
    output logic        stall,
`ifdef IFID_PERF_EN
    output logic [31:0] perf_stall_cnt,
    output logic [31:0] perf_flush_cnt,
`endif
    output logic        id_bubble
);

    logic hazard;

    hazard_detect u_hazard_detect (
        .instruction   (id_instruction),
        .valid         (id_valid),
        .idex_mem_read (idex_mem_read),
        .idex_rd       (idex_rd),
        .hazard        (hazard)
    );

    // A flush kills the held instruction anyway, so it must not also freeze Fetch.
    assign stall     = hazard && !flush;
    assign id_bubble = hazard || flush;

    // Pipeline register: reset > flush > stall (hold) > load.
    always_ff @(posedge Clk) begin
        if (reset || flush) begin
            id_pc          <= 64'd0;
            id_instruction <= NOP_INSTR;
            id_valid       <= 1'b0;
        end else if (!stall) begin
            id_pc          <= if_pc;
            id_instruction <= if_instruction;
            id_valid       <= 1'b1;
        end
    end

`ifdef IFID_PERF_EN
    // Free-running wrap-around counts of stall and flush cycles.
    always_ff @(posedge Clk) begin
        if (reset) begin
            perf_stall_cnt <= 32'd0;
            perf_flush_cnt <= 32'd0;
        end else begin
            if (stall) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (flush) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Directed bench for if_id_stage: register expectations go through a scoreboard queue,
// combinational stall/bubble are compared directly against constants.
module tb_if_id_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        Clk = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] if_pc = '0;
    logic [31:0] if_instruction = '0;
    logic        flush = 1'b0;
    logic        idex_mem_read = 1'b0;
    logic [4:0]  idex_rd = '0;
    logic [63:0] id_pc;
    logic [31:0] id_instruction;
    logic        id_valid;
    logic        stall;
    logic        id_bubble;
`ifdef IFID_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_stall_cnt = 0;
    int m_flush_cnt = 0;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] ins;
        logic        v;
    } exp_t;
    exp_t sb[$];

    if_id_stage dut (
        .Clk            (Clk),
        .reset          (reset),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .flush          (flush),
        .idex_mem_read  (idex_mem_read),
        .idex_rd        (idex_rd),
        .id_pc          (id_pc),
        .id_instruction (id_instruction),
        .id_valid       (id_valid),
        .stall          (stall),
`ifdef IFID_PERF_EN
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt),
`endif
        .id_bubble      (id_bubble)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_regs(input logic [63:0] pc, input logic [31:0] ins, input logic v);
        exp_t e;
        e.pc = pc; e.ins = ins; e.v = v;
        sb.push_back(e);
    endtask

    // Advance one edge; s/f are the stall/flush levels the bench knows hold during this cycle.
    task automatic step(input string tag, input bit s, input bit f);
        exp_t e;
        if (reset) begin
            m_stall_cnt = 0;
            m_flush_cnt = 0;
        end else begin
            m_stall_cnt += int'(s);
            m_flush_cnt += int'(f);
        end
        @(posedge Clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s scoreboard empty observed=none expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, ".id_pc"}, id_pc, e.pc);
            chk({tag, ".id_instruction"}, 64'(id_instruction), 64'(e.ins));
            chk({tag, ".id_valid"}, 64'(id_valid), 64'(e.v));
        end
    endtask

    task automatic comb(input string tag, input logic s, input logic b);
        #1;
        chk({tag, ".stall"}, 64'(stall), 64'(s));
        chk({tag, ".id_bubble"}, 64'(id_bubble), 64'(b));
    endtask

    task automatic chk_perf(input string tag);
`ifdef IFID_PERF_EN
        chk({tag, ".perf_stall_cnt"}, 64'(perf_stall_cnt), 64'(m_stall_cnt));
        chk({tag, ".perf_flush_cnt"}, 64'(perf_flush_cnt), 64'(m_flush_cnt));
`else
        if (tag.len() == 0) $display("no perf counters");
`endif
    endtask

    initial begin
        // Reset state
        expect_regs(64'd0, NOP, 1'b0);
        step("reset", 0, 0);
        reset = 1'b0;
        comb("after_reset", 0, 0);
        chk_perf("after_reset");

        // IF -> ID in one cycle
        if_pc = 64'h8; if_instruction = 32'h003100B3;  // add x1,x2,x3
        expect_regs(64'h8, 32'h003100B3, 1'b1);
        step("load_add", 0, 0);
        comb("load_add", 0, 0);

        // add x8,x7,x7 with a load to x7 in EX
        if_pc = 64'h10; if_instruction = 32'h00738433;
        expect_regs(64'h10, 32'h00738433, 1'b1);
        step("load_dep", 0, 0);
        idex_mem_read = 1'b1; idex_rd = 5'd7;
        if_pc = 64'h14; if_instruction = 32'h01053383;  // ld x7,16(x10)
        comb("hazard_rs", 1, 1);
        expect_regs(64'h10, 32'h00738433, 1'b1);
        step("hold", 1, 0);
        comb("hazard_still", 1, 1);
        idex_mem_read = 1'b0;
        comb("hazard_clear", 0, 0);
        expect_regs(64'h14, 32'h01053383, 1'b1);
        step("advance", 0, 0);

        // Load in ID: rs2 field is immediate, x0 never hazards
        idex_mem_read = 1'b1; idex_rd = 5'd16;
        comb("ld_rs2_unused", 0, 0);
        idex_rd = 5'd10;
        comb("ld_rs1", 1, 1);
        idex_rd = 5'd0;
        comb("rd_x0", 0, 0);

        // Store reads rs2
        idex_mem_read = 1'b0;
        if_pc = 64'h18; if_instruction = 32'h00533023;  // sd x5,0(x6)
        expect_regs(64'h18, 32'h00533023, 1'b1);
        step("load_sd", 0, 0);
        idex_mem_read = 1'b1; idex_rd = 5'd5;
        comb("sd_rs2", 1, 1);
        idex_rd = 5'd6;
        comb("sd_rs1", 1, 1);

        // OP-IMM ignores rs2 field
        idex_mem_read = 1'b0;
        if_pc = 64'h1c; if_instruction = 32'h00510093;  // addi x1,x2,5
        expect_regs(64'h1c, 32'h00510093, 1'b1);
        step("load_addi", 0, 0);
        idex_mem_read = 1'b1; idex_rd = 5'd5;
        comb("addi_imm", 0, 0);
        idex_rd = 5'd2;
        comb("addi_rs1", 1, 1);

        // Flush beats simultaneous hazard
        flush = 1'b1;
        if_pc = 64'h20; if_instruction = 32'h00208063;  // beq x1,x2,0
        comb("flush_hazard", 0, 1);
        expect_regs(64'd0, NOP, 1'b0);
        step("flush", 0, 1);
        flush = 1'b0;
        comb("post_flush_invalid", 0, 0);
        expect_regs(64'h20, 32'h00208063, 1'b1);
        step("load_beq", 0, 0);

        // Branch reads rs2; then reset in the middle of the stall
        if_pc = 64'h24; if_instruction = 32'h00000033;
        comb("beq_rs2", 1, 1);
        expect_regs(64'h20, 32'h00208063, 1'b1);
        step("beq_hold", 1, 0);
        reset = 1'b1;
        expect_regs(64'd0, NOP, 1'b0);
        step("reset_mid_stall", 1, 0);
        reset = 1'b0;
        comb("reset_mid_stall", 0, 0);

        // Reset and flush together
        idex_mem_read = 1'b0;
        if_pc = 64'h28; if_instruction = 32'h003100B3;
        expect_regs(64'h28, 32'h003100B3, 1'b1);
        step("load_pre_rf", 0, 0);
        reset = 1'b1; flush = 1'b1;
        expect_regs(64'd0, NOP, 1'b0);
        step("reset_flush", 0, 1);
        reset = 1'b0; flush = 1'b0;
        comb("reset_flush", 0, 0);
        chk_perf("after_reset_flush");

        // Three stall cycles then two flush cycles
        if_pc = 64'h40; if_instruction = 32'h00738433;
        expect_regs(64'h40, 32'h00738433, 1'b1);
        step("perf_load", 0, 0);
        idex_mem_read = 1'b1; idex_rd = 5'd7;
        if_pc = 64'h44; if_instruction = 32'h003100B3;
        for (int i = 0; i < 3; i++) begin
            expect_regs(64'h40, 32'h00738433, 1'b1);
            step("perf_stall", 1, 0);
        end
        flush = 1'b1;
        for (int i = 0; i < 2; i++) begin
            expect_regs(64'd0, NOP, 1'b0);
            step("perf_flush", 0, 1);
        end
        flush = 1'b0; idex_mem_read = 1'b0;
        chk_perf("perf_counts");
        reset = 1'b1;
        expect_regs(64'd0, NOP, 1'b0);
        step("perf_reset", 0, 0);
        reset = 1'b0;
        chk_perf("perf_cleared");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
